// File: rtl/alu_sequencer.sv
// Four-register ALU sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK, one instruction per 4 cycles.
// Define ALU_SEQ_FLAGS_EN to add the flag_z/flag_n result-flag outputs.
module alu_sequencer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wb_valid,
  output logic [1:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic              flag_z,
  output logic              flag_n,
`endif
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StDecode, StExecute, StWriteback} state_e;

  state_e            state_q, state_d;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
  logic [1:0]        ctrl_q;

  logic [1:0]        ir_op, ir_rd, ir_rs, ir_rt;
  logic              ir_imm_sel;
  logic [DATA_W-1:0] ir_imm;
  logic              unused_ir_reserved;

  assign ir_op      = ir_q[15:14];
  assign ir_rd      = ir_q[13:12];
  assign ir_rs      = ir_q[11:10];
  assign ir_imm_sel = ir_q[9];
  assign ir_rt      = ir_q[1:0];
  assign ir_imm     = DATA_W'(ir_q[7:0]);
  assign unused_ir_reserved = ir_q[8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (instr_valid) state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (instr_valid) ir_q <= instr;
        StDecode: begin
          // Operands are read here, so WRITEBACK of this instruction never affects them
          op_a_q <= regs_q[ir_rs];
          op_b_q <= ir_imm_sel ? ir_imm : regs_q[ir_rt];
          ctrl_q <= ir_op;
        end
        StExecute:   result_q <= alu_result;
        StWriteback: regs_q[ir_rd] <= result_q;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z_q, flag_n_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (state_q == StWriteback) begin
      flag_z_q <= (result_q == '0);
      flag_n_q <= result_q[DATA_W-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

  // Operand latches only change in DECODE, so the ALU inputs hold their last values elsewhere
  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign alu_control = ctrl_q;

  assign instr_ready = (state_q == StIdle);
  assign wb_valid    = (state_q == StWriteback);
  assign wb_addr     = ir_rd;
  assign wb_data     = result_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule
